// File: rtl/cache_write_queue_if.sv
// Cache write port bundle: pipeline control, store/load/AMO sources, the cache
// entry read back at the store index, and the single arbitrated write port.
interface cache_write_queue_if #(
  parameter int XLEN            = 32,
  parameter int CacheIndexWidth = 7,
  parameter int CacheTagWidth   = 7,
  parameter int QueueDepth      = 4
);
  localparam int ByteLanes  = XLEN / 8;
  localparam int CountWidth = $clog2(QueueDepth) + 1;

  logic                       i_stall;
  logic                       i_flush;
  logic [ByteLanes-1:0]       i_store_be;
  logic [CacheIndexWidth-1:0] i_store_index;
  logic [CacheTagWidth-1:0]   i_store_tag;
  logic [XLEN-1:0]            i_store_data;
  logic                       i_load_valid;
  logic [CacheIndexWidth-1:0] i_load_index;
  logic [CacheTagWidth-1:0]   i_load_tag;
  logic [XLEN-1:0]            i_load_data;
  logic                       i_amo_we;
  logic [CacheIndexWidth-1:0] i_amo_index;
  logic [CacheTagWidth-1:0]   i_amo_tag;
  logic [XLEN-1:0]            i_amo_data;
  logic [CacheTagWidth-1:0]   i_cache_read_tag;
  logic [ByteLanes-1:0]       i_cache_read_valid;
  logic                       o_we;
  logic [ByteLanes-1:0]       o_be;
  logic [CacheIndexWidth-1:0] o_index;
  logic [CacheTagWidth-1:0]   o_tag;
  logic [XLEN-1:0]            o_data;
  logic [ByteLanes-1:0]       o_valid;
  logic                       o_queue_full;
  logic [CountWidth-1:0]      o_queue_count;

  modport master (
    output i_stall, i_flush, i_store_be, i_store_index, i_store_tag, i_store_data,
           i_load_valid, i_load_index, i_load_tag, i_load_data,
           i_amo_we, i_amo_index, i_amo_tag, i_amo_data,
           i_cache_read_tag, i_cache_read_valid,
    input  o_we, o_be, o_index, o_tag, o_data, o_valid, o_queue_full, o_queue_count
  );

  modport slave (
    input  i_stall, i_flush, i_store_be, i_store_index, i_store_tag, i_store_data,
           i_load_valid, i_load_index, i_load_tag, i_load_data,
           i_amo_we, i_amo_index, i_amo_tag, i_amo_data,
           i_cache_read_tag, i_cache_read_valid,
    output o_we, o_be, o_index, o_tag, o_data, o_valid, o_queue_full, o_queue_count
  );
endinterface

// File: rtl/cache_write_queue.sv
// Arbitrates the cache write port (AMO > store > load-fill drain) and queues load fills.
// Optional CACHE_WRITE_QUEUE_MERGE_EN: same-tag stores merge into queued fills instead of killing them.
module cache_write_queue #(
  parameter int XLEN            = 32,
  parameter int CacheIndexWidth = 7,
  parameter int CacheTagWidth   = 7,
  parameter int QueueDepth      = 4
) (
  input logic i_clk,
  input logic i_rst,
  cache_write_queue_if.slave bus
);
  localparam int ByteLanes  = XLEN / 8;
  localparam int PtrWidth   = $clog2(QueueDepth);
  localparam int CountWidth = PtrWidth + 1;

  logic [CacheIndexWidth-1:0] q_index [QueueDepth];
  logic [CacheTagWidth-1:0]   q_tag   [QueueDepth];
  logic [XLEN-1:0]            q_data  [QueueDepth];
  logic [QueueDepth-1:0]      q_live, live_next, kill_vec;
  logic [PtrWidth-1:0]        rd_ptr, wr_ptr;
  logic [CountWidth-1:0]      count;

  logic                       store_we, write_en, empty, full, pop, push, push_live;
  logic [CacheIndexWidth-1:0] wr_index;
  logic [XLEN-1:0]            push_data;

  assign store_we = |bus.i_store_be;
  assign write_en = bus.i_amo_we | store_we;
  assign wr_index = bus.i_amo_we ? bus.i_amo_index : bus.i_store_index;
  assign empty    = (count == '0);
  assign full     = (count == CountWidth'(QueueDepth));
  assign pop      = ~empty & ~write_en;
  assign push     = bus.i_load_valid & ~bus.i_stall & ~bus.i_flush & (~full | pop);

`ifdef CACHE_WRITE_QUEUE_MERGE_EN
  logic [QueueDepth-1:0] merge_vec;
  logic                  push_merge;

  function automatic logic [XLEN-1:0] merge_bytes(input logic [XLEN-1:0] old_d,
                                                  input logic [XLEN-1:0] new_d,
                                                  input logic [ByteLanes-1:0] be);
    logic [XLEN-1:0] r;
    r = old_d;
    for (int b = 0; b < ByteLanes; b++)
      if (be[b]) r[b*8 +: 8] = new_d[b*8 +: 8];
    return r;
  endfunction
`endif

  // The store/AMO being written is younger than every queued fill, so matching fills must not land after it.
  always_comb begin
    kill_vec  = '0;
    push_live = 1'b1;
    push_data = bus.i_load_data;
`ifdef CACHE_WRITE_QUEUE_MERGE_EN
    merge_vec  = '0;
    push_merge = 1'b0;
    for (int i = 0; i < QueueDepth; i++)
      if (write_en && q_live[i] && q_index[i] == wr_index) begin
        if (!bus.i_amo_we && q_tag[i] == bus.i_store_tag) merge_vec[i] = 1'b1;
        else                                              kill_vec[i]  = 1'b1;
      end
    if (write_en && bus.i_load_index == wr_index) begin
      if (!bus.i_amo_we && bus.i_load_tag == bus.i_store_tag) push_merge = 1'b1;
      else                                                    push_live  = 1'b0;
    end
    if (push_merge) push_data = merge_bytes(bus.i_load_data, bus.i_store_data, bus.i_store_be);
`else
    for (int i = 0; i < QueueDepth; i++)
      if (write_en && q_live[i] && q_index[i] == wr_index) kill_vec[i] = 1'b1;
    if (write_en && bus.i_load_index == wr_index) push_live = 1'b0;
`endif
    live_next = q_live & ~kill_vec;
    if (pop)  live_next[rd_ptr] = 1'b0;
    if (push) live_next[wr_ptr] = push_live;
  end

  always_ff @(posedge i_clk) begin
`ifdef CACHE_WRITE_QUEUE_MERGE_EN
    for (int i = 0; i < QueueDepth; i++)
      if (merge_vec[i]) q_data[i] <= merge_bytes(q_data[i], bus.i_store_data, bus.i_store_be);
`endif
    if (push) begin
      q_index[wr_ptr] <= bus.i_load_index;
      q_tag[wr_ptr]   <= bus.i_load_tag;
      q_data[wr_ptr]  <= push_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      q_live <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      q_live <= live_next;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    bus.o_we    = 1'b0;
    bus.o_be    = '0;
    bus.o_valid = '0;
    bus.o_index = q_index[rd_ptr];
    bus.o_tag   = q_tag[rd_ptr];
    bus.o_data  = q_data[rd_ptr];
    if (bus.i_amo_we) begin
      bus.o_we    = 1'b1;
      bus.o_be    = '1;
      bus.o_valid = '1;
      bus.o_index = bus.i_amo_index;
      bus.o_tag   = bus.i_amo_tag;
      bus.o_data  = bus.i_amo_data;
    end else if (store_we) begin
      bus.o_we    = 1'b1;
      bus.o_be    = bus.i_store_be;
      bus.o_valid = (bus.i_cache_read_tag == bus.i_store_tag)
                    ? (bus.i_store_be | bus.i_cache_read_valid) : bus.i_store_be;
      bus.o_index = bus.i_store_index;
      bus.o_tag   = bus.i_store_tag;
      bus.o_data  = bus.i_store_data;
    end else if (!empty) begin
      bus.o_we    = q_live[rd_ptr];
      bus.o_be    = '1;
      bus.o_valid = '1;
    end
    if (i_rst) bus.o_we = 1'b0;
  end

  assign bus.o_queue_full  = full;
  assign bus.o_queue_count = count;
endmodule

// File: tb/tb_cache_write_queue.sv
// Directed vector bench for cache_write_queue: per-cycle stimulus rows with expected
// write-port outputs and queue occupancy, plus hand-written reset sequences.
module tb_cache_write_queue;
`ifdef CACHE_WRITE_QUEUE_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  typedef struct {
    logic        lv;  logic [6:0] li; logic [6:0] lt; logic [31:0] ld;
    logic [3:0]  sbe; logic [6:0] si; logic [6:0] st; logic [31:0] sd;
    logic        amo; logic [6:0] ai; logic [31:0] ad;
    logic [6:0]  crt; logic [3:0] crv;
    logic        stall; logic flush;
    logic        ewe; logic [3:0] ebe; logic [6:0] ei; logic [6:0] et; logic [31:0] ed;
    logic [3:0]  ev;  logic [2:0] ecnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  cache_write_queue_if bus ();
  cache_write_queue dut (.i_clk(clk), .i_rst(rst), .bus(bus.slave));

  function automatic vec_t mk(
    input logic lv, input logic [6:0] li, input logic [6:0] lt, input logic [31:0] ld,
    input logic [3:0] sbe, input logic [6:0] si, input logic [6:0] st, input logic [31:0] sd,
    input logic amo, input logic [6:0] ai, input logic [31:0] ad,
    input logic [6:0] crt, input logic [3:0] crv, input logic stall, input logic flush,
    input logic ewe, input logic [3:0] ebe, input logic [6:0] ei, input logic [6:0] et,
    input logic [31:0] ed, input logic [3:0] ev, input logic [2:0] ecnt);
    vec_t v;
    v.lv = lv; v.li = li; v.lt = lt; v.ld = ld;
    v.sbe = sbe; v.si = si; v.st = st; v.sd = sd;
    v.amo = amo; v.ai = ai; v.ad = ad; v.crt = crt; v.crv = crv;
    v.stall = stall; v.flush = flush;
    v.ewe = ewe; v.ebe = ebe; v.ei = ei; v.et = et; v.ed = ed; v.ev = ev; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.i_load_valid = v.lv;  bus.i_load_index = v.li; bus.i_load_tag = v.lt; bus.i_load_data = v.ld;
    bus.i_store_be = v.sbe;   bus.i_store_index = v.si; bus.i_store_tag = v.st; bus.i_store_data = v.sd;
    bus.i_amo_we = v.amo;     bus.i_amo_index = v.ai; bus.i_amo_tag = 7'd0; bus.i_amo_data = v.ad;
    bus.i_cache_read_tag = v.crt; bus.i_cache_read_valid = v.crv;
    bus.i_stall = v.stall;    bus.i_flush = v.flush;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_vec(input int n, input vec_t v);
    chk($sformatf("v%0d we", n), 32'(bus.o_we), 32'(v.ewe));
    chk($sformatf("v%0d count", n), 32'(bus.o_queue_count), 32'(v.ecnt));
    chk($sformatf("v%0d full", n), 32'(bus.o_queue_full), 32'(v.ecnt == 3'd4));
    if (v.ewe) begin
      chk($sformatf("v%0d be", n), 32'(bus.o_be), 32'(v.ebe));
      chk($sformatf("v%0d index", n), 32'(bus.o_index), 32'(v.ei));
      chk($sformatf("v%0d tag", n), 32'(bus.o_tag), 32'(v.et));
      chk($sformatf("v%0d data", n), bus.o_data, v.ed);
      chk($sformatf("v%0d valid", n), 32'(bus.o_valid), 32'(v.ev));
    end
  endtask

  localparam logic [31:0] D = 32'hDEAD_BEEF;

  initial begin
    // lv li lt ld | sbe si st sd | amo ai ad | crt crv | stall flush | ewe ebe ei et ed ev | cnt
    vecs.push_back(mk(0,0,0,0,            0,0,0,0,       0,0,0, 0,0, 0,0, 0,0,0,0,0,0, 0));
    vecs.push_back(mk(1,1,0,32'h11,       4'hF,7'h70,0,D, 0,0,0, 0,0, 0,0, 1,4'hF,7'h70,0,D,4'hF, 0));
    vecs.push_back(mk(1,2,0,32'h22,       4'hF,7'h70,0,D, 0,0,0, 0,0, 0,0, 1,4'hF,7'h70,0,D,4'hF, 1));
    vecs.push_back(mk(1,3,0,32'h33,       4'hF,7'h70,0,D, 0,0,0, 0,0, 0,0, 1,4'hF,7'h70,0,D,4'hF, 2));
    vecs.push_back(mk(1,4,0,32'h44,       4'hF,7'h70,0,D, 0,0,0, 0,0, 0,0, 1,4'hF,7'h70,0,D,4'hF, 3));
    vecs.push_back(mk(1,9,0,32'h99,       4'hF,7'h70,0,D, 0,0,0, 0,0, 0,0, 1,4'hF,7'h70,0,D,4'hF, 4));
    vecs.push_back(mk(1,9,0,32'h99,       0,0,0,0,       0,0,0, 0,0, 0,0, 1,4'hF,1,0,32'h11,4'hF, 4));
    vecs.push_back(mk(0,0,0,0,            0,0,0,0,       0,0,0, 0,0, 0,0, 1,4'hF,2,0,32'h22,4'hF, 4));
    vecs.push_back(mk(0,0,0,0,            0,0,0,0,       0,0,0, 0,0, 0,0, 1,4'hF,3,0,32'h33,4'hF, 3));
    vecs.push_back(mk(0,0,0,0,            0,0,0,0,       0,0,0, 0,0, 0,0, 1,4'hF,4,0,32'h44,4'hF, 2));
    vecs.push_back(mk(0,0,0,0,            0,0,0,0,       0,0,0, 0,0, 0,0, 1,4'hF,9,0,32'h99,4'hF, 1));
    vecs.push_back(mk(0,0,0,0,            0,0,0,0,       0,0,0, 0,0, 0,0, 0,0,0,0,0,0, 0));
    vecs.push_back(mk(0,0,0,0,            4'h3,7'h10,5,32'h55, 0,0,0, 5,4'hC, 0,0, 1,4'h3,7'h10,5,32'h55,4'hF, 0));
    vecs.push_back(mk(0,0,0,0,            4'h3,7'h10,5,32'h55, 0,0,0, 6,4'hC, 0,0, 1,4'h3,7'h10,5,32'h55,4'h3, 0));
    vecs.push_back(mk(1,3,0,32'h33,       4'hF,7'h70,0,D, 0,0,0, 0,0, 0,0, 1,4'hF,7'h70,0,D,4'hF, 0));
    vecs.push_back(mk(1,6,0,32'h66,       4'hF,7'h70,0,D, 0,0,0, 0,0, 0,0, 1,4'hF,7'h70,0,D,4'hF, 1));
    vecs.push_back(mk(0,0,0,0,            4'hF,7'h71,0,D, 1,3,32'hA3A3_A3A3, 0,0, 0,0, 1,4'hF,3,0,32'hA3A3_A3A3,4'hF, 2));
    vecs.push_back(mk(0,0,0,0,            0,0,0,0,       0,0,0, 0,0, 0,0, 0,0,0,0,0,0, 2));
    vecs.push_back(mk(0,0,0,0,            0,0,0,0,       0,0,0, 0,0, 0,0, 1,4'hF,6,0,32'h66,4'hF, 1));
    vecs.push_back(mk(0,0,0,0,            0,0,0,0,       0,0,0, 0,0, 0,0, 0,0,0,0,0,0, 0));
    vecs.push_back(mk(1,5,2,32'hAAAA_AAAA, 4'hF,7'h70,0,D, 0,0,0, 0,0, 0,0, 1,4'hF,7'h70,0,D,4'hF, 0));
    vecs.push_back(mk(0,0,0,0,            4'h1,5,2,32'hBB, 0,0,0, 0,0, 0,0, 1,4'h1,5,2,32'hBB,4'h1, 1));
    vecs.push_back(mk(0,0,0,0,            0,0,0,0,       0,0,0, 0,0, 0,0, MERGE,4'hF,5,2,32'hAAAA_AABB,4'hF, 1));
    vecs.push_back(mk(0,0,0,0,            0,0,0,0,       0,0,0, 0,0, 0,0, 0,0,0,0,0,0, 0));
    vecs.push_back(mk(1,8,1,32'h88,       4'hF,8,0,32'h1234_5678, 0,0,0, 0,0, 0,0, 1,4'hF,8,0,32'h1234_5678,4'hF, 0));
    vecs.push_back(mk(0,0,0,0,            0,0,0,0,       0,0,0, 0,0, 0,0, 0,0,0,0,0,0, 1));
    vecs.push_back(mk(0,0,0,0,            0,0,0,0,       0,0,0, 0,0, 0,0, 0,0,0,0,0,0, 0));
    vecs.push_back(mk(1,7'hC,0,32'hCC,    4'hF,7'h70,0,D, 0,0,0, 0,0, 0,0, 1,4'hF,7'h70,0,D,4'hF, 0));
    vecs.push_back(mk(1,7'hD,0,32'hDD,    0,0,0,0,       0,0,0, 0,0, 0,1, 1,4'hF,7'hC,0,32'hCC,4'hF, 1));
    vecs.push_back(mk(0,0,0,0,            0,0,0,0,       0,0,0, 0,0, 0,0, 0,0,0,0,0,0, 0));
    vecs.push_back(mk(1,7'hE,0,32'hEE,    0,0,0,0,       0,0,0, 0,0, 1,0, 0,0,0,0,0,0, 0));
    vecs.push_back(mk(0,0,0,0,            0,0,0,0,       0,0,0, 0,0, 0,0, 0,0,0,0,0,0, 0));

    // Reset held with every source active: the write port must stay quiet.
    drive(mk(1,1,0,32'h11, 4'hF,7'h70,0,D, 1,2,32'h5, 0,0, 0,0, 0,0,0,0,0,0, 0));
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #2;
      chk($sformatf("reset we c%0d", c), 32'(bus.o_we), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < vecs.size(); n++) begin
      if (n != 0) @(negedge clk);
      drive(vecs[n]);
      #2;
      check_vec(n, vecs[n]);
    end

    // Reset in the middle of a drain discards the queued fills.
    @(negedge clk);
    drive(mk(1,7'h20,0,32'h20, 4'hF,7'h70,0,D, 0,0,0, 0,0, 0,0, 0,0,0,0,0,0, 0));
    @(negedge clk);
    drive(mk(1,7'h21,0,32'h21, 4'hF,7'h70,0,D, 0,0,0, 0,0, 0,0, 0,0,0,0,0,0, 0));
    #2;
    chk("pre-reset count", 32'(bus.o_queue_count), 32'd1);
    @(negedge clk);
    drive(mk(0,0,0,0, 0,0,0,0, 0,0,0, 0,0, 0,0, 0,0,0,0,0,0, 0));
    #2;
    chk("drain before reset we", 32'(bus.o_we), 32'd1);
    chk("drain before reset index", 32'(bus.o_index), 32'h20);
    rst = 1'b1;
    #1;
    chk("mid-drain reset we", 32'(bus.o_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("post-reset count", 32'(bus.o_queue_count), 32'd0);
    chk("post-reset full", 32'(bus.o_queue_full), 32'd0);
    chk("post-reset we", 32'(bus.o_we), 32'd0);
    @(negedge clk); #2;
    chk("post-reset idle we", 32'(bus.o_we), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
